// File: rtl/ha_seradd_pkg.sv
// ---------------------------------------------------------------------------
// ha_seradd_pkg
// Shared definitions for the bit-serial adder controller:
//   state_t              - controller FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   HA_SERADD_WIDTH_DEF  - default operand width
//   cnt_width()          - width of the bit counter for a given operand width
// No ports (package).
// ---------------------------------------------------------------------------
package ha_seradd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int HA_SERADD_WIDTH_DEF = 8;

  // Counter must address bits 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ha.sv
// ---------------------------------------------------------------------------
// ha
// Half-adder cell.
// Ports:
//   a, b : input bits
//   s    : sum (a ^ b)
//   c    : carry (a & b)
// ---------------------------------------------------------------------------
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/ha_fa_bit.sv
// ---------------------------------------------------------------------------
// ha_fa_bit
// One-bit full adder built from two half-adder cells; the two partial
// carries can never both be 1, so an OR merges them.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
// ---------------------------------------------------------------------------
module ha_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  ha u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/ha_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// ha_serial_adder_ctrl
// Bit-serial WIDTH-bit adder. Operands are accepted with a valid/ready
// handshake, summed one bit per cycle through a single ha_fa_bit cell, and
// the result is offered with a second valid/ready handshake.
//
// Optional feature macro: HA_SERADD_SUB_EN
//   When defined, adds port op_sub; op_sub=1 at accept computes A + ~B + 1
//   (A - B), and carry_out=1 then means "no borrow".
//
// Parameters:
//   WIDTH     - operand/result width, 2..64
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands presented
//   in_ready  - operands accepted (combinational, high only in IDLE)
//   op_a      - addend A
//   op_b      - addend B
//   op_sub    - subtract select (only with HA_SERADD_SUB_EN)
//   out_valid - result valid (registered)
//   out_ready - consumer accepts result
//   sum       - result (registered)
//   carry_out - final carry / not-borrow (registered)
//   busy      - high in RUN or DONE (registered)
// ---------------------------------------------------------------------------
module ha_serial_adder_ctrl
  import ha_seradd_pkg::*;
#(
  parameter int WIDTH = HA_SERADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef HA_SERADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_reg,     state_next;
  logic [WIDTH-1:0] a_sh_reg,      a_sh_next;
  logic [WIDTH-1:0] b_sh_reg,      b_sh_next;
  logic [WIDTH-1:0] res_reg,       res_next;
  logic             carry_reg,     carry_next;
  logic [CW-1:0]    cnt_reg,       cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic             carry_out_reg, carry_out_next;
  logic             busy_reg,      busy_next;

  // Subtract select and the B operand as it will be latched.
  logic             sub_sel;
  logic [WIDTH-1:0] op_b_eff;

`ifdef HA_SERADD_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Conditional per-bit inversion of B for subtraction.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign op_b_eff[gi] = op_b[gi] ^ sub_sel;
    end
  endgenerate

  // The single shared full-adder cell.
  logic fa_s;
  logic fa_cout;

  ha_fa_bit u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      carry_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_sh_reg      <= a_sh_next;
      b_sh_reg      <= b_sh_next;
      res_reg       <= res_next;
      carry_reg     <= carry_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      carry_out_reg <= carry_out_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next     = state_reg;
    a_sh_next      = a_sh_reg;
    b_sh_next      = b_sh_reg;
    res_next       = res_reg;
    carry_next     = carry_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    carry_out_next = carry_out_reg;
    busy_next      = busy_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_next  = op_a;
          b_sh_next  = op_b_eff;
          cnt_next   = '0;
          carry_next = sub_sel;
          busy_next  = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // LSB-first: each sum bit enters at the MSB, so after WIDTH shifts
        // bit 0 of the result has arrived at position 0.
        res_next   = {fa_s, res_reg[WIDTH-1:1]};
        carry_next = fa_cout;
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        if (cnt_reg == LAST) begin
          // Counter holds at the terminal count rather than wrapping.
          carry_out_next = fa_cout;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign sum       = res_reg;
  assign carry_out = carry_out_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ha_serial_adder_ctrl
// Self-checking bench for ha_serial_adder_ctrl (WIDTH=8). Directed cases
// followed by a randomized valid/ready stream scored against a plain
// arithmetic reference. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_ha_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int checks;
  int failures;

  ha_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef HA_SERADD_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full (W+1)-bit result of A + B, or A + ~B + 1 for subtract.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
  endfunction

  // One directed transaction; hold = cycles to keep out_ready low in DONE,
  // during which a competing in_valid is presented and must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input string tag);
    logic [W:0]   exp;
    int           lat;
    exp = ref_calc(a, b, sub);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(W));
    check_eq({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check_eq({tag, "_carry"}, 64'(carry_out), 64'(exp[W]));
    for (int h = 0; h < hold; h++) begin
      op_a = 8'h77; op_b = 8'h11; in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_sum"}, 64'(sum), 64'(exp[W-1:0]));
      check_eq({tag, "_hold_carry"}, 64'(carry_out), 64'(exp[W]));
      check_eq({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_busy_clr"}, 64'(busy), 64'd0);
    $display("txn %s a=%02h b=%02h sub=%0d sum=%02h carry=%0d", tag, a, b, sub, exp[W-1:0], exp[W]);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } op_t;

  initial begin
    op_t          q[$];
    op_t          e;
    logic [W:0]   r;
    int           sent;
    int           rcvd;
    int           cyc;
    logic         sub_en;

    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0;
`ifdef HA_SERADD_SUB_EN
    sub_en = 1'b1;
`else
    sub_en = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_carry", 64'(carry_out), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 0, "ripple");
    run_op(8'hA5, 8'h5A, 1'b0, 5, "stall");
    check_eq("stall_ignored_busy", 64'(busy), 64'd0);

    // Reset in the middle of RUN
    op_a = 8'h12; op_b = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_sum", 64'(sum), 64'd0);
    check_eq("midrst_carry", 64'(carry_out), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    run_op(8'h12, 8'h34, 1'b0, 0, "after_rst");

    if (sub_en) begin
      run_op(8'h05, 8'h07, 1'b1, 0, "sub_borrow");
      run_op(8'h07, 8'h05, 1'b1, 0, "sub_noborrow");
    end

    // Randomized stream with random valid/ready gaps
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 200 && cyc < 20000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      op_a      = W'($urandom);
      op_b      = W'($urandom);
      op_sub    = sub_en & $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        e.a = op_a; e.b = op_b; e.sub = op_sub;
        q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("stream_extra", 64'(rcvd), 64'(sent));
        end else begin
          e = q.pop_front();
          r = ref_calc(e.a, e.b, e.sub);
          check_eq("stream_sum", 64'(sum), 64'(r[W-1:0]));
          check_eq("stream_carry", 64'(carry_out), 64'(r[W]));
          $display("txn stream %0d a=%02h b=%02h sub=%0d sum=%02h carry=%0d",
                   rcvd, e.a, e.b, e.sub, sum, carry_out);
        end
        rcvd++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("stream_count", 64'(rcvd), 64'd200);
    check_eq("stream_pending", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
